// File: rtl/fft_frame_pkg.sv
// Purpose : shared constants, FSM state type and sample helpers for fft_frame_loader.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: FRAME_LEN, SAMPLE_W, OUT_W, IDX_W, state_e, sext_sample(), and when
//           FFT_FRAME_LOADER_WINDOW_EN is defined, the WIN Hann table and win_sample().
package fft_frame_pkg;

  localparam int FRAME_LEN = 16;
  localparam int SAMPLE_W  = 10;
  localparam int OUT_W     = 16;
  localparam int IDX_W     = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Sign-extend a raw 10-bit two's complement tap to the output width.
  function automatic logic [OUT_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(OUT_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

`ifdef FFT_FRAME_LOADER_WINDOW_EN
  // Periodic 16-point Hann window scaled so the peak (index 8) is exactly 256.
  localparam logic [8:0] WIN [FRAME_LEN] = '{
    9'd0,   9'd10,  9'd37,  9'd79,  9'd128, 9'd177, 9'd219, 9'd246,
    9'd256, 9'd246, 9'd219, 9'd177, 9'd128, 9'd79,  9'd37,  9'd10
  };

  // sample * w >>> 8. Since w <= 256 the result always fits back into
  // SAMPLE_W signed bits, so truncating the shifted product is lossless.
  function automatic logic [OUT_W-1:0] win_sample(input logic [SAMPLE_W-1:0] s,
                                                  input logic [8:0]          w);
    logic signed [SAMPLE_W+9:0] prod;
    prod = $signed(s) * $signed({1'b0, w});
    prod = prod >>> 8;
    return OUT_W'(prod);
  endfunction
`endif

endpackage

// File: rtl/pulse_sync.sv
// Purpose : 2-flop synchroniser for an asynchronous level plus rising-edge detector.
// Latency : pulse_o asserts 2-3 clk edges after async_i rises (one-clk pulse).
// Backpr. : none; every synchronised rising edge produces exactly one pulse.
// Ports   : clk_i, rst_n_i (async active-low), async_i (foreign-domain level),
//           pulse_o (one-cycle event in clk_i domain).
module pulse_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic pulse_o
);

  // [0] metastability catcher, [1] synchronised level, [2] delayed copy for edge detect
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fft_frame_loader.sv
// Purpose : snapshots a 16-tap sample delay line every HOP new-sample events and
//           streams it as one 16-word frame (oldest first) to a downstream FFT.
// Latency : out_valid rises the clk edge after the snapshot; new_t to snapshot is
//           3 clk edges through the synchroniser.
// Backpr. : valid/ready per word; outputs hold during stalls. A trigger arriving
//           while a frame is still streaming is dropped and counted in overrun_cnt.
// Ports   : clk, reset (async active-low), new_t (async sample flag), t0..t15 taps
//           (t0 newest, 10-bit signed in [9:0]), out_data/out_valid/out_ready/
//           out_sop/out_eop/out_idx stream, busy, overrun_cnt (saturating).
// Config  : define FFT_FRAME_LOADER_WINDOW_EN to apply the Hann window to out_data.
module fft_frame_loader
  import fft_frame_pkg::*;
#(
  parameter int HOP   = 4,  // events between frame starts, 1..16
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_t,
  input  logic [15:0]      t0,
  input  logic [15:0]      t1,
  input  logic [15:0]      t2,
  input  logic [15:0]      t3,
  input  logic [15:0]      t4,
  input  logic [15:0]      t5,
  input  logic [15:0]      t6,
  input  logic [15:0]      t7,
  input  logic [15:0]      t8,
  input  logic [15:0]      t9,
  input  logic [15:0]      t10,
  input  logic [15:0]      t11,
  input  logic [15:0]      t12,
  input  logic [15:0]      t13,
  input  logic [15:0]      t14,
  input  logic [15:0]      t15,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int               HOP_W    = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int               WARM_W   = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // Tap gathering: only [9:0] of each tap carries the sample.
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] tap_w [FRAME_LEN];
  logic                unused_tap_hi;

  assign tap_w[0]  = t0[SAMPLE_W-1:0];
  assign tap_w[1]  = t1[SAMPLE_W-1:0];
  assign tap_w[2]  = t2[SAMPLE_W-1:0];
  assign tap_w[3]  = t3[SAMPLE_W-1:0];
  assign tap_w[4]  = t4[SAMPLE_W-1:0];
  assign tap_w[5]  = t5[SAMPLE_W-1:0];
  assign tap_w[6]  = t6[SAMPLE_W-1:0];
  assign tap_w[7]  = t7[SAMPLE_W-1:0];
  assign tap_w[8]  = t8[SAMPLE_W-1:0];
  assign tap_w[9]  = t9[SAMPLE_W-1:0];
  assign tap_w[10] = t10[SAMPLE_W-1:0];
  assign tap_w[11] = t11[SAMPLE_W-1:0];
  assign tap_w[12] = t12[SAMPLE_W-1:0];
  assign tap_w[13] = t13[SAMPLE_W-1:0];
  assign tap_w[14] = t14[SAMPLE_W-1:0];
  assign tap_w[15] = t15[SAMPLE_W-1:0];

  assign unused_tap_hi = ^{t0[15:SAMPLE_W],  t1[15:SAMPLE_W],  t2[15:SAMPLE_W],  t3[15:SAMPLE_W],
                           t4[15:SAMPLE_W],  t5[15:SAMPLE_W],  t6[15:SAMPLE_W],  t7[15:SAMPLE_W],
                           t8[15:SAMPLE_W],  t9[15:SAMPLE_W],  t10[15:SAMPLE_W], t11[15:SAMPLE_W],
                           t12[15:SAMPLE_W], t13[15:SAMPLE_W], t14[15:SAMPLE_W], t15[15:SAMPLE_W]};

  // ---------------------------------------------------------------------------
  // Event generation, warm-up and hop counting
  // ---------------------------------------------------------------------------
  logic evt_w;

  pulse_sync u_sync (
    .clk_i   (clk),
    .rst_n_i (reset),
    .async_i (new_t),
    .pulse_o (evt_w)
  );

  logic [WARM_W-1:0] warm_q, warm_d;
  logic [HOP_W-1:0]  hop_q,  hop_d;
  logic              trig_w;
  logic              warm_ok_w;

  // The trigger fires on the HOP-th event; the counter wraps on that same event.
  assign trig_w = evt_w && (hop_q == HOP_W'(HOP - 1));

  // warm_q counts events already seen; a trigger is itself an event, so the
  // frame may start on the event that brings the total to FRAME_LEN.
  assign warm_ok_w = (warm_q >= WARM_W'(FRAME_LEN - 1));

  always_comb begin
    hop_d  = hop_q;
    warm_d = warm_q;
    if (evt_w) begin
      hop_d = trig_w ? '0 : hop_q + HOP_W'(1);
      if (warm_q != WARM_W'(FRAME_LEN)) begin
        warm_d = warm_q + WARM_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, snapshot buffer and overrun counter
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [OVR_W-1:0]    ovr_q,   ovr_d;
  logic [SAMPLE_W-1:0] buf_q [FRAME_LEN];
  logic [SAMPLE_W-1:0] buf_d [FRAME_LEN];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        // Triggers during warm-up are simply discarded, not counted as overruns.
        if (trig_w && warm_ok_w) begin
          state_d = ST_STREAM;
          idx_d   = '0;
          // Word 0 is the oldest tap (t15), word 15 the newest (t0).
          for (int i = 0; i < FRAME_LEN; i++) begin
            buf_d[i] = tap_w[FRAME_LEN-1-i];
          end
        end
      end
      ST_STREAM: begin
        // Includes a trigger landing on the final transfer edge: the frame is
        // still owned at that point, so the trigger is lost.
        if (trig_w && (ovr_q != '1)) begin
          ovr_d = ovr_q + OVR_W'(1);
        end
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ovr_q   <= '0;
      hop_q   <= '0;
      warm_q  <= '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      hop_q   <= hop_d;
      warm_q  <= warm_d;
      buf_q   <= buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: all outputs decode from registered state, so they are stable
  // across stalls and drop to zero as soon as reset asserts.
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] cur_w;
  logic [OUT_W-1:0]    word_w;

  assign cur_w = buf_q[idx_q];

`ifdef FFT_FRAME_LOADER_WINDOW_EN
  assign word_w = win_sample(cur_w, WIN[idx_q]);
`else
  assign word_w = sext_sample(cur_w);
`endif

  assign out_valid   = (state_q == ST_STREAM);
  assign busy        = (state_q == ST_STREAM);
  assign out_idx     = idx_q;
  assign out_sop     = out_valid && (idx_q == '0);
  assign out_eop     = out_valid && (idx_q == LAST_IDX);
  assign out_data    = out_valid ? word_w : '0;
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter HOP, default 4, meaning new-sample events between frame starts (legal 1..16).
REQ-002 SHALL have parameter OVR_W, default 8, meaning overrun counter width.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_t  input  1  new-sample flag from the BCLK domain, asynchronous to clk.
REQ-006 SHALL have ports t0..t15  input  16 each  sample taps: t0 newest, t15 oldest, 10-bit two's complement in bits [9:0].
REQ-007 SHALL have port out_data  output  16  frame sample, sign-extended.
REQ-008 SHALL have port out_valid  output  1  out_data/out_idx/out_sop/out_eop are valid.
REQ-009 SHALL have port out_ready  input  1  downstream FFT accepts the current word.
REQ-010 SHALL have ports out_sop, out_eop  output  1 each  first and last word of a frame.
REQ-011 SHALL have port out_idx  output  4  sample index within the frame (0..15).
REQ-012 SHALL have port busy  output  1  a frame is streaming.
REQ-013 SHALL have port overrun_cnt  output  OVR_W  count of dropped frame triggers, saturating.

Function
REQ-014 SHALL synchronise new_t through a 2-flop synchroniser and generate a one-clk event on its synchronised rising edge.
REQ-015 SHALL implement states IDLE and STREAM only.
REQ-016 SHALL keep a warm-up counter; no frame SHALL start until 16 events have occurred since reset.
REQ-017 SHALL keep a hop counter, increment it per event, and raise a trigger when it reaches HOP; the counter then returns to 0.
REQ-018 On a trigger in IDLE, SHALL snapshot t15..t0 into a 16-entry frame buffer in the same cycle and enter STREAM.
REQ-019 SHALL assert out_valid on the clk edge after the snapshot.
REQ-020 SHALL present words in order idx 0 = t15 (oldest) through idx 15 = t0 (newest).
REQ-021 SHALL set out_data to bits [9:0] sign-extended to 16 bits (window disabled).
REQ-022 SHALL transfer a word only on a clk edge where out_valid and out_ready are both high; out_idx then increments.
REQ-023 SHALL hold out_data, out_idx, out_sop and out_eop stable while out_valid=1 and out_ready=0.
REQ-024 SHALL assert out_sop only at idx 0 and out_eop only at idx 15.
REQ-025 After the idx-15 transfer, SHALL drop out_valid and busy on the same edge and return to IDLE.
REQ-026 SHALL drive busy=1 exactly while in STREAM.
REQ-027 On a trigger in STREAM, SHALL drop that trigger, increment overrun_cnt (saturating at all-ones), and leave the current frame unchanged.
REQ-028 SHALL treat a trigger coinciding with the final (idx 15) transfer as an overrun.
REQ-029 Taps changing during STREAM SHALL NOT affect the buffered frame.

Reset
REQ-030 While reset=0, SHALL asynchronously force IDLE with out_valid=0, out_sop=0, out_eop=0, busy=0, out_idx=0, out_data=0, overrun_cnt=0, and clear the hop counter, warm-up counter and synchroniser.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no word SHALL be emitted after reset releases until a new warm-up and trigger complete.

Configuration
REQ-032 With FFT_FRAME_LOADER_WINDOW_EN defined, SHALL set out_data to (sample x WIN[idx]) arithmetic-shifted right by 8 and sign-extended to 16 bits, where WIN is a 9-bit unsigned Hann table (peak 256); latency and handshake SHALL be unchanged.
REQ-033 Without FFT_FRAME_LOADER_WINDOW_EN, SHALL apply no window, and the multiplier and table SHALL be absent.

Structure
REQ-034 Package fft_frame_pkg SHALL hold FRAME_LEN=16, SAMPLE_W=10, OUT_W=16, the state enum and the WIN table.
REQ-035 Sub-module pulse_sync SHALL implement the 2-flop synchroniser and rising-edge detector.

Verification
REQ-036 Reset, then 16 events with taps t15..t0 = 0x001..0x010, and out_ready=1 -> one frame 0x0001..0x0010 in consecutive cycles, with sop at idx 0 and eop at idx 15.
REQ-037 Tap 0x3FF (-1) -> out_data 0xFFFF; tap 0x200 -> 0xFE00.
REQ-038 out_ready toggled 1/0 every cycle -> 16 transfers over 31 cycles, with outputs stable during stalls.
REQ-039 HOP=1 with out_ready=0 held for 40 cycles while 3 events arrive -> overrun_cnt=3, and the first frame completes intact on release.
REQ-040 Reset asserted at idx 7 -> all outputs are 0 immediately, and no further valid appears until 16 events plus a trigger.
REQ-041 With FFT_FRAME_LOADER_WINDOW_EN, all taps 0x100 -> out_data = 256 x WIN[i] >> 8 = WIN[i] at each idx.
